dec_npipe: RTL and testbench

DEC_NPIPE -- requirements
Module: dec_npipe

---
 rtl/dec_npipe.sv | 83 ++++++++
 tb/tb_dec_npipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_npipe.sv
// Single-stage registered address decoder (one-hot / thermometer)
// with valid/ready handshake on both sides and an accept counter.
module dec_npipe #(
  parameter int AW   = 3,
  parameter int NOUT = 8,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   a,
  input  logic            en,
  input  logic            mode,
  output logic [NOUT-1:0] d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err,
  output logic [CW-1:0]   cnt
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  localparam logic [AW:0] NOUT_L = NOUT[AW:0];

  state_e          state_q, state_d;
  logic [NOUT-1:0] d_q, d_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NOUT-1:0] pat;
  logic            in_range;
  logic            accept;

  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign in_range  = {1'b0, a} < NOUT_L;
  assign d         = d_q;
  assign err       = err_q;
  assign out_valid = (state_q == FULL);
  assign cnt       = cnt_q;

  always_comb begin
    pat = '0;
    for (int i = 0; i < NOUT; i++) begin
      pat[i] = mode ? (AW'(i) <= a) : (AW'(i) == a);
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      d_d     = (en && in_range) ? pat : '0;
      err_d   = en && !in_range;
      cnt_d   = cnt_q + CW'(1);
    end else if (state_q == FULL && out_ready) begin
      // drained: pattern stays, error flag drops
      state_d = EMPTY;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dec_npipe.sv
// Bench for dec_npipe: default instance plus a NOUT=6, CW=2 instance,
// directed scenarios and randomized traffic against a shift-based model.
module tb_dec_npipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv[2];
  logic [2:0] ia[2];
  logic       ien[2];
  logic       imd[2];
  logic       ordy[2];

  logic       ir0, ir1, ov0, ov1, e0, e1;
  logic [7:0] d0, c0;
  logic [5:0] d1;
  logic [1:0] c1;

  int n_chk = 0;
  int n_fail = 0;

  bit         m_v[2];
  logic [7:0] m_d[2];
  bit         m_e[2];
  int         m_c[2];
  int         nout[2] = '{8, 6};
  int         cmod[2] = '{256, 4};

  always #5 clk = ~clk;

  dec_npipe u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir0),
    .a(ia[0]), .en(ien[0]), .mode(imd[0]),
    .d(d0), .out_valid(ov0), .out_ready(ordy[0]),
    .err(e0), .cnt(c0)
  );

  dec_npipe #(.AW(3), .NOUT(6), .CW(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir1),
    .a(ia[1]), .en(ien[1]), .mode(imd[1]),
    .d(d1), .out_valid(ov1), .out_ready(ordy[1]),
    .err(e1), .cnt(c1)
  );

  function automatic logic [7:0] g_d(int k);
    return (k == 0) ? d0 : {2'b00, d1};
  endfunction
  function automatic logic g_v(int k);
    return (k == 0) ? ov0 : ov1;
  endfunction
  function automatic logic g_e(int k);
    return (k == 0) ? e0 : e1;
  endfunction
  function automatic logic g_r(int k);
    return (k == 0) ? ir0 : ir1;
  endfunction
  function automatic int g_c(int k);
    return (k == 0) ? int'(c0) : int'(c1);
  endfunction

  function automatic logic [7:0] pat(int av, bit e, bit md, int n);
    int v;
    if (!e || av >= n) return 8'h00;
    v = md ? ((1 << (av + 1)) - 1) : (1 << av);
    return v[7:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_d[k] = 8'h00; m_e[k] = 0; m_c[k] = 0;
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; ien[k] = 0; imd[k] = 0; ordy[k] = 1;
    end
  endtask

  task automatic tick();
    bit rdy;
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        rdy = !m_v[k] || ordy[k];
        if (iv[k] && rdy) begin
          m_v[k] = 1;
          m_d[k] = pat(int'(ia[k]), ien[k], imd[k], nout[k]);
          m_e[k] = ien[k] && (int'(ia[k]) >= nout[k]);
          m_c[k] = (m_c[k] + 1) % cmod[k];
        end else if (m_v[k] && ordy[k]) begin
          m_v[k] = 0;
          m_e[k] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (g_d(k) !== 8'h00 || g_v(k) !== 1'b0 || g_e(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got d=%h v=%b e=%b required 0/0/0",
                 k, g_d(k), g_v(k), g_e(k));
      end
      n_chk++;
      if (g_c(k) != 0) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d]: got %0d required 0", k, g_c(k));
      end
      n_chk++;
      if (g_r(k) !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready[%0d]: got %b required 1", k, g_r(k));
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (ir0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b required 1", ir0);
    end
  endtask

  task automatic test_onehot();
    iv[0] = 1; ia[0] = 3'd5; ien[0] = 1; imd[0] = 0; ordy[0] = 1;
    tick();
    iv[0] = 0;
    n_chk++;
    if (d0 !== 8'b0010_0000 || ov0 !== 1'b1 || e0 !== 1'b0) begin
      n_fail++;
      $display("FAIL onehot_a5: got d=%b v=%b e=%b required 00100000/1/0",
               d0, ov0, e0);
    end
    n_chk++;
    if (c0 !== 8'd1) begin
      n_fail++;
      $display("FAIL onehot_cnt: got %0d required 1", c0);
    end
  endtask

  task automatic test_thermo();
    iv[0] = 1; ia[0] = 3'd3; ien[0] = 1; imd[0] = 1;
    tick();
    n_chk++;
    if (d0 !== 8'b0000_1111) begin
      n_fail++;
      $display("FAIL thermo_a3: got %b required 00001111", d0);
    end
    ia[0] = 3'd0;
    tick();
    iv[0] = 0;
    n_chk++;
    if (d0 !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL thermo_a0: got %b required 00000001", d0);
    end
  endtask

  task automatic test_range();
    int c_before;
    c_before = int'(c1);
    iv[1] = 1; ia[1] = 3'd6; ien[1] = 1; imd[1] = 0; ordy[1] = 1;
    tick();
    n_chk++;
    if (d1 !== 6'd0 || e1 !== 1'b1 || ov1 !== 1'b1) begin
      n_fail++;
      $display("FAIL range_a6: got d=%b e=%b v=%b required 0/1/1",
               d1, e1, ov1);
    end
    ia[1] = 3'd7; ien[1] = 0;
    tick();
    iv[1] = 0;
    n_chk++;
    if (d1 !== 6'd0 || e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL range_en0: got d=%b e=%b required 0/0", d1, e1);
    end
    n_chk++;
    if (int'(c1) != (c_before + 2) % 4) begin
      n_fail++;
      $display("FAIL range_cnt: got %0d required %0d",
               c1, (c_before + 2) % 4);
    end
    tick();
    n_chk++;
    if (ov1 !== 1'b0 || e1 !== 1'b0 || d1 !== 6'd0) begin
      n_fail++;
      $display("FAIL range_drain: got v=%b e=%b d=%b required 0/0/0",
               ov1, e1, d1);
    end
  endtask

  task automatic test_stall();
    iv[0] = 1; ia[0] = 3'd2; ien[0] = 1; imd[0] = 0; ordy[0] = 1;
    tick();
    ordy[0] = 0; ia[0] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (ir0 !== 1'b0 || d0 !== 8'b0000_0100 || ov0 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got r=%b d=%b v=%b required 0/00000100/1",
                 i, ir0, d0, ov0);
      end
      tick();
    end
    ordy[0] = 1;
    #1;
    n_chk++;
    if (ir0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b required 1", ir0);
    end
    tick();
    iv[0] = 0;
    n_chk++;
    if (d0 !== 8'b1000_0000 || ov0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_bubble: got d=%b v=%b required 10000000/1",
               d0, ov0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1; ia[0] = 3'(i % 8); ien[0] = 1; imd[0] = 0; ordy[0] = 1;
      tick();
      exp_d = 8'(1 << (i % 8));
      n_chk++;
      if (d0 !== exp_d || ov0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got d=%b v=%b required %b/1",
                 i, d0, ov0, exp_d);
      end
    end
    iv[0] = 0;
    n_chk++;
    if (c0 !== 8'd16) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d required 16", c0);
    end
  endtask

  task automatic test_wrap_async();
    do_reset();
    n_chk++;
    if (c1 !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt0: got %0d required 0", c1);
    end
    for (int i = 0; i < 5; i++) begin
      iv[1] = 1; ia[1] = 3'd1; ien[1] = 1; imd[1] = 1; ordy[1] = 1;
      tick();
      n_chk++;
      if (int'(c1) != (i + 1) % 4) begin
        n_fail++;
        $display("FAIL wrap_cnt[%0d]: got %0d required %0d",
                 i, c1, (i + 1) % 4);
      end
    end
    iv[1] = 0; ordy[1] = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ov1 !== 1'b0 || d1 !== 6'd0 || c1 !== 2'd0 || e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%b c=%0d e=%b required 0/0/0/0",
               ov1, d1, c1, e1);
    end
    model_clear();
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_chk++;
    if (ov1 !== 1'b0 || d1 !== 6'd0 || ir1 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_clean: got v=%b d=%b r=%b required 0/0/1",
               ov1, d1, ir1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ia[k]   = 3'($urandom_range(0, 7));
        ien[k]  = ($urandom_range(0, 5) != 0);
        imd[k]  = 1'($urandom_range(0, 1));
        ordy[k] = ($urandom_range(0, 2) != 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (g_r(k) !== (!m_v[k] || ordy[k])) begin
          n_fail++;
          $display("FAIL rnd_ready[%0d] n=%0d: got %b required %b",
                   k, n, g_r(k), (!m_v[k] || ordy[k]));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (g_d(k) !== m_d[k] || g_v(k) !== m_v[k] || g_e(k) !== m_e[k]) begin
          n_fail++;
          $display("FAIL rnd_out[%0d] n=%0d: got d=%h v=%b e=%b required %h/%b/%b",
                   k, n, g_d(k), g_v(k), g_e(k), m_d[k], m_v[k], m_e[k]);
        end
        n_chk++;
        if (g_c(k) != m_c[k]) begin
          n_fail++;
          $display("FAIL rnd_cnt[%0d] n=%0d: got %0d required %0d",
                   k, n, g_c(k), m_c[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    test_reset();
    test_onehot();
    test_thermo();
    test_range();
    test_stall();
    test_back_to_back();
    test_wrap_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
